// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the fetch front end.
// Types only; no logic, latency or flow control here.
package rv32_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            epoch;
    } inflight_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that clears everything.
// Head visible the cycle after push; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok  = i_push && !i_flush && (r_count != FULL_CNT);
    assign w_pop_ok   = i_pop && (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC generator and in-order word fetcher feeding decode through a flushable queue.
// Response reaches decode one cycle later; requests stall when in-flight plus queued would exceed FQ_DEPTH.
module fetch_redirect_unit
    import rv32_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int          CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FQ_DEPTH);

    logic [XLEN-1:0]             r_pc;
    logic                        r_epoch;

    logic [CW-1:0]               w_trk_count;
    logic [CW-1:0]               w_fq_count;
    logic [$bits(inflight_t)-1:0]    w_trk_head_dat;
    logic [$bits(fetch_entry_t)-1:0] w_fq_head_dat;
    inflight_t                   w_trk_head;
    inflight_t                   w_trk_push;
    fetch_entry_t                w_fq_head;
    fetch_entry_t                w_fq_push;

    logic                        w_req_fire;
    logic                        w_rsp_pop;
    logic                        w_rsp_keep;
    logic                        w_dec_pop;
    logic [CW:0]                 w_used;
    logic                        w_credit;

    assign w_trk_head = inflight_t'(w_trk_head_dat);
    assign w_fq_head  = fetch_entry_t'(w_fq_head_dat);

    // The head slot freed by this cycle's decode pop is already available,
    // which is what sustains one fetch per cycle at unit memory latency.
    assign w_dec_pop  = dec_valid && dec_ready;
    assign w_used     = {1'b0, w_trk_count} + {1'b0, w_fq_count} - {{CW{1'b0}}, w_dec_pop};
    assign w_credit   = w_used < CREDITS;

    assign imem_req_valid = !rst && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_pop  = imem_rsp_valid && (w_trk_count != '0);
    assign w_rsp_keep = w_rsp_pop && !redirect_valid && (w_trk_head.epoch == r_epoch);

    assign w_trk_push = '{pc: r_pc, epoch: r_epoch};
    assign w_fq_push  = '{pc: w_trk_head.pc, instr: imem_rsp_data};

    assign dec_valid = (w_fq_count != '0);
    assign dec_instr = dec_valid ? w_fq_head.instr : '0;
    assign dec_pc    = dec_valid ? w_fq_head.pc    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_epoch <= 1'b0;
        end else if (redirect_valid) begin
            r_pc    <= word_align(redirect_pc);
            r_epoch <= ~r_epoch;
        end else if (w_req_fire) begin
            r_pc    <= r_pc + 32'd4;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(inflight_t)),
        .DEPTH (FQ_DEPTH)
    ) u_inflight (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (1'b0),
        .i_push     (w_req_fire),
        .i_push_dat (w_trk_push),
        .i_pop      (w_rsp_pop),
        .o_head_dat (w_trk_head_dat),
        .o_count    (w_trk_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_q (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (redirect_valid),
        .i_push     (w_rsp_keep),
        .i_push_dat (w_fq_push),
        .i_pop      (w_dec_pop),
        .o_head_dat (w_fq_head_dat),
        .o_count    (w_fq_count)
    );

    a_rsp_has_tag: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (w_trk_count != '0));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with an in-order memory model of configurable latency.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] iss_addr[$];
    int          iss_cyc[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    int          got_cyc[$];

    int   cyc   = 0;
    int   lat   = 1;
    int   total = 0;
    int   bad   = 0;
    logic tb_rst       = 1'b1;
    logic tb_ready     = 1'b1;
    logic tb_dec_ready = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later.
    task automatic step(input logic redir = 1'b0, input logic [31:0] rpc = 32'h0);
        @(negedge clk);
        rst            = tb_rst;
        imem_req_ready = tb_ready;
        dec_ready      = tb_dec_ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
            mq.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc + lat});
            iss_addr.push_back(imem_req_addr);
            iss_cyc.push_back(cyc);
        end
        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            got_pc.push_back(dec_pc);
            got_instr.push_back(dec_instr);
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic clear_logs();
        iss_addr.delete();
        iss_cyc.delete();
        got_pc.delete();
        got_instr.delete();
        got_cyc.delete();
    endtask

    task automatic do_reset();
        mq.delete();
        tb_rst = 1'b1;
        step();
        step();
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        tb_rst = 1'b0;
        clear_logs();
    endtask

    initial begin
        int          rel;
        int          stale;
        logic [31:0] held;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        dec_ready = 1'b1;

        // Streaming at unit latency: one fetch per cycle, decode two cycles after issue.
        lat = 1; tb_ready = 1'b1; tb_dec_ready = 1'b1;
        do_reset();
        rel = cyc;
        repeat (12) step();
        check("t1_n_iss", 32'(iss_addr.size() >= 6), 32'h1);
        check("t1_n_got", 32'(got_pc.size() >= 6), 32'h1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_addr%0d", i), iss_addr[i], 32'(4 * i));
            check($sformatf("t1_icyc%0d", i), 32'(iss_cyc[i]), 32'(rel + i));
            check($sformatf("t1_pc%0d", i), got_pc[i], 32'(4 * i));
            check($sformatf("t1_instr%0d", i), got_instr[i], ~(32'(4 * i)));
            check($sformatf("t1_dcyc%0d", i), 32'(got_cyc[i]), 32'(rel + i + 2));
        end

        // Decode stalled: two requests fill the credits, then resume at 0x8.
        lat = 1; tb_dec_ready = 1'b0;
        do_reset();
        repeat (6) step();
        check("t2_n_iss", 32'(iss_addr.size()), 32'd2);
        check("t2_req_valid", 32'(imem_req_valid), 32'h0);
        check("t2_dec_valid", 32'(dec_valid), 32'h1);
        check("t2_dec_pc", dec_pc, 32'h0);
        check("t2_dec_instr", dec_instr, 32'hFFFF_FFFF);
        tb_dec_ready = 1'b1;
        repeat (6) step();
        check("t2_resume", iss_addr[2], 32'h8);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_pc%0d", i), got_pc[i], 32'(4 * i));
        end

        // Redirect with 0x10 and 0x14 in flight.
        lat = 3; tb_dec_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 60 && iss_addr.size() < 6; k++) step();
        check("t3_setup_n", 32'(iss_addr.size()), 32'd6);
        check("t3_setup_last", iss_addr[5], 32'h14);
        check("t3_setup_out", 32'(mq.size()), 32'd2);
        step(1'b1, 32'h200);
        check("t3_redir_suppress", 32'(imem_req_valid), 32'h0);
        clear_logs();
        step();
        check("t3_next_addr", imem_req_addr, 32'h200);
        repeat (14) step();
        check("t3_first_iss", iss_addr[0], 32'h200);
        check("t3_pc0", got_pc[0], 32'h200);
        check("t3_pc1", got_pc[1], 32'h204);
        check("t3_instr0", got_instr[0], ~32'h200);

        // Unaligned target is word-aligned.
        lat = 1;
        do_reset();
        repeat (3) step();
        step(1'b1, 32'h303);
        clear_logs();
        step();
        check("t4_addr", imem_req_addr, 32'h300);
        repeat (6) step();
        check("t4_pc0", got_pc[0], 32'h300);

        // Back-to-back redirects with slow memory: last target wins.
        lat = 3;
        do_reset();
        repeat (4) step();
        step(1'b1, 32'h100);
        step(1'b1, 32'h400);
        clear_logs();
        repeat (20) step();
        check("t5_first_iss", iss_addr[0], 32'h400);
        check("t5_pc0", got_pc[0], 32'h400);
        check("t5_pc1", got_pc[1], 32'h404);
        check("t5_pc2", got_pc[2], 32'h408);
        stale = 0;
        foreach (got_pc[i]) if (got_pc[i][31:8] != 24'h4) stale++;
        check("t5_no_stale", 32'(stale), 32'h0);

        // Memory not ready for 4 cycles: address and valid hold, pc moves only on handshake.
        lat = 1;
        do_reset();
        repeat (5) step();
        tb_ready = 1'b0;
        step();
        held = imem_req_addr;
        check("t6_held_val", held, 32'h14);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check($sformatf("t6_valid%0d", i), 32'(imem_req_valid), 32'h1);
            check($sformatf("t6_addr%0d", i), imem_req_addr, 32'h14);
        end
        tb_ready = 1'b1;
        clear_logs();
        repeat (4) step();
        check("t6_fire0", iss_addr[0], 32'h14);
        check("t6_fire1", iss_addr[1], 32'h18);

        // PC wraps past the top of the address space.
        lat = 1;
        do_reset();
        repeat (2) step();
        step(1'b1, 32'hFFFF_FFFC);
        clear_logs();
        repeat (8) step();
        check("t7_iss0", iss_addr[0], 32'hFFFF_FFFC);
        check("t7_iss1", iss_addr[1], 32'h0);
        check("t7_iss2", iss_addr[2], 32'h4);
        check("t7_pc0", got_pc[0], 32'hFFFF_FFFC);
        check("t7_pc1", got_pc[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
